// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the memory-stage load/store unit.
//   DataWidth    : data / instruction-address path width
//   RegAddrWidth : register-file address width
//   lsuState_e   : LSU FSM state encoding (IDLE=0, REQ=1, WAIT=2, DONE=3)
//   isMemOp      : true when the MEM-stage instruction needs the data memory
package mem_stage_lsu_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned RegAddrWidth = 5;

  typedef enum logic [1:0] {
    LsuIdle = 2'd0,
    LsuReq  = 2'd1,
    LsuWait = 2'd2,
    LsuDone = 2'd3
  } lsuState_e;

  // Store takes priority over load when both flags are set; either way it is a memop.
  function automatic logic isMemOp(input logic valid, input logic dataWe, input logic regSel);
    return valid & (dataWe | regSel);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and the data memory (slave).
//   dmem_req_o    : request valid (master -> slave)
//   dmem_we_o     : 1 = write
//   dmem_addr_o   : word-aligned address
//   dmem_wdata_o  : write data
//   dmem_gnt_i    : request accepted this cycle (slave -> master)
//   dmem_rvalid_i : read data valid
//   dmem_rdata_i  : read data
interface mem_stage_lsu_if
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned XLEN = DataWidth
);

  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic            dmem_gnt_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

endinterface

// File: rtl/lsu_timeout_counter.sv
// Access timeout counter for the LSU.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : zero the count (entering REQ)
//   enable   : count this cycle (REQ or WAIT)
//   expired  : count has reached TIMEOUT_CYCLES-1
module lsu_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt;

  // Saturates at the last value so a stuck enable can never wrap and hide the expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CntLast)) begin
      cnt <= cnt + CntW'(1);
    end
  end

  assign expired = (cnt == CntLast);

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Takes the EXE/MEM register outputs, performs word loads and
// stores over the req/gnt/rvalid bus, stalls upstream while an access is in flight, and drives
// the MEM/WB writeback fields.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, a memop whose address has
// [1:0] != 0 is aborted with err_o without touching memory; otherwise those bits are dropped.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   valid_i                : MEM stage holds a live instruction
//   pc_mem                 : pc of the MEM-stage instruction
//   registerWriteEnable_i  : instruction writes rd
//   dataWriteEnable_i      : store
//   regSelect_i            : 1 = load (writeback from memory), 0 = ALU result
//   regDest_i              : rd
//   aluOut_i               : ALU result, also the load/store address
//   dataB_i                : store data
//   stall_o                : freeze PC, IF/ID, ID/EXE, EXE/MEM
//   dmem                   : data-memory bus (master side)
//   wb_valid_o             : one-cycle pulse per retiring instruction
//   pc_wb, registerWriteEnable_o, regDest_o, wbData_o : writeback fields
//   err_o                  : access aborted (pulses with wb_valid_o)
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned XLEN           = DataWidth,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic [XLEN-1:0]         pc_mem,
  input  logic                    registerWriteEnable_i,
  input  logic                    dataWriteEnable_i,
  input  logic                    regSelect_i,
  input  logic [RegAddrWidth-1:0] regDest_i,
  input  logic [XLEN-1:0]         aluOut_i,
  input  logic [XLEN-1:0]         dataB_i,
  output logic                    stall_o,
  mem_stage_lsu_if.master         dmem,
  output logic                    wb_valid_o,
  output logic [XLEN-1:0]         pc_wb,
  output logic                    registerWriteEnable_o,
  output logic [RegAddrWidth-1:0] regDest_o,
  output logic [XLEN-1:0]         wbData_o,
  output logic                    err_o
);

  lsuState_e               state;
  logic [XLEN-1:2]         addrQ;
  logic [XLEN-1:0]         wdataQ;
  logic                    weQ;
  logic [XLEN-1:0]         pcQ;
  logic                    regWeQ;
  logic [RegAddrWidth-1:0] rdQ;

  logic memOp;
  logic misaligned;
  logic inFlight;
  logic finishOk;
  logic finishErr;
  logic expired;

  always_comb begin
    memOp = isMemOp(valid_i, dataWriteEnable_i, regSelect_i);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = (aluOut_i[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    inFlight = (state == LsuReq) || (state == LsuWait);
    // Store completes on gnt; load completes on gnt+rvalid in REQ or on rvalid in WAIT.
    finishOk = ((state == LsuReq) && dmem.dmem_gnt_i && (weQ || dmem.dmem_rvalid_i)) ||
               ((state == LsuWait) && dmem.dmem_rvalid_i);
    // A completing handshake on the expiry cycle wins over the timeout.
    finishErr = inFlight && expired && !finishOk;
    // Gated by rst so every output reads 0 while reset is held.
    stall_o = rst && (((state == LsuIdle) && memOp) || inFlight);
  end

  assign dmem.dmem_req_o   = (state == LsuReq);
  assign dmem.dmem_we_o    = weQ;
  assign dmem.dmem_addr_o  = {addrQ, 2'b00};
  assign dmem.dmem_wdata_o = wdataQ;

  lsu_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == LsuIdle) && memOp),
    .enable (inFlight),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= LsuIdle;
      addrQ                 <= '0;
      wdataQ                <= '0;
      weQ                   <= 1'b0;
      pcQ                   <= '0;
      regWeQ                <= 1'b0;
      rdQ                   <= '0;
      wb_valid_o            <= 1'b0;
      pc_wb                 <= '0;
      registerWriteEnable_o <= 1'b0;
      regDest_o             <= '0;
      wbData_o              <= '0;
      err_o                 <= 1'b0;
    end else begin
      wb_valid_o            <= 1'b0;
      registerWriteEnable_o <= 1'b0;
      err_o                 <= 1'b0;
      unique case (state)
        LsuIdle: begin
          if (memOp) begin
            addrQ  <= aluOut_i[XLEN-1:2];
            wdataQ <= dataB_i;
            weQ    <= dataWriteEnable_i;
            pcQ    <= pc_mem;
            regWeQ <= registerWriteEnable_i;
            rdQ    <= regDest_i;
            if (misaligned) begin
              // Trap without a bus request; retire with err and no register write.
              state      <= LsuDone;
              wb_valid_o <= 1'b1;
              err_o      <= 1'b1;
              pc_wb      <= pc_mem;
              regDest_o  <= regDest_i;
              wbData_o   <= '0;
            end else begin
              state <= LsuReq;
            end
          end else if (valid_i) begin
            wb_valid_o            <= 1'b1;
            pc_wb                 <= pc_mem;
            registerWriteEnable_o <= registerWriteEnable_i;
            regDest_o             <= regDest_i;
            wbData_o              <= aluOut_i;
          end
        end
        LsuReq, LsuWait: begin
          if (finishOk || finishErr) begin
            state                 <= LsuDone;
            wb_valid_o            <= 1'b1;
            pc_wb                 <= pcQ;
            regDest_o             <= rdQ;
            registerWriteEnable_o <= finishOk && regWeQ && !weQ;
            wbData_o              <= (finishOk && !weQ) ? dmem.dmem_rdata_i : '0;
            err_o                 <= finishErr;
          end else if ((state == LsuReq) && dmem.dmem_gnt_i) begin
            state <= LsuWait;
          end
        end
        LsuDone: begin
          // The EXE/MEM register still shows the finished memop here; the next one is
          // sampled back in IDLE.
          state <= LsuIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int unsigned Xlen    = 32;
  localparam int unsigned Timeout = 64;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } wbExp_t;

  logic        clk;
  logic        rst;
  logic        valid, rwe, dwe, rsel;
  logic [31:0] pc, alu, dataB;
  logic [4:0]  rd;
  logic        stall, wbValid, wbRegWe, err;
  logic [31:0] pcWb, wbData;
  logic [4:0]  rdWb;

  wbExp_t sbQ[$];
  wbExp_t monExp;
  int     checks = 0;
  int     errors = 0;
  int     pushCount = 0;
  int     wbCount = 0;
  int     stalls, reqs;

  mem_stage_lsu_if #(.XLEN(Xlen)) dmem ();

  mem_stage_lsu #(
    .XLEN          (Xlen),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .valid_i              (valid),
    .pc_mem               (pc),
    .registerWriteEnable_i(rwe),
    .dataWriteEnable_i    (dwe),
    .regSelect_i          (rsel),
    .regDest_i            (rd),
    .aluOut_i             (alu),
    .dataB_i              (dataB),
    .stall_o              (stall),
    .dmem                 (dmem),
    .wb_valid_o           (wbValid),
    .pc_wb                (pcWb),
    .registerWriteEnable_o(wbRegWe),
    .regDest_o            (rdWb),
    .wbData_o             (wbData),
    .err_o                (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic w, input logic [4:0] r,
                      input logic [31:0] d, input logic e);
    wbExp_t x;
    x.pc = p; x.we = w; x.rd = r; x.data = d; x.err = e;
    sbQ.push_back(x);
    pushCount++;
  endtask

  task automatic setIns(input logic v, input logic [31:0] p, input logic rw, input logic dw,
                        input logic rs, input logic [4:0] r, input logic [31:0] a,
                        input logic [31:0] b);
    valid = v; pc = p; rwe = rw; dwe = dw; rsel = rs; rd = r; alu = a; dataB = b;
  endtask

  // Caller has just driven a memop at a negedge. Plays the memory side (gnt on cycle gntAt,
  // rvalid on cycle rvAt, counted from the first cycle after issue) until stall drops.
  task automatic runAccess(input int gntAt, input int rvAt, input logic [31:0] rdat,
                           input logic [31:0] expAddr, input logic expWe,
                           input logic [31:0] expWdata, output int nStall, output int nReq);
    logic done;
    done = 1'b0;
    #1;
    chk("issue_stall", stall, 1'b1);
    chk("issue_no_req", dmem.dmem_req_o, 1'b0);
    nStall = 1;
    nReq = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      dmem.dmem_gnt_i    = (c == gntAt);
      dmem.dmem_rvalid_i = (c == rvAt);
      dmem.dmem_rdata_i  = (c == rvAt) ? rdat : 32'hBAD0BAD0;
      #1;
      if (dmem.dmem_req_o === 1'b1) begin
        nReq++;
        chk("req_addr", dmem.dmem_addr_o, expAddr);
        chk("req_we", dmem.dmem_we_o, expWe);
        if (expWe) chk("req_wdata", dmem.dmem_wdata_o, expWdata);
      end
      if (stall !== 1'b1) begin
        done = 1'b1;
        break;
      end
      nStall++;
    end
    chk("access_done", done, 1'b1);
    dmem.dmem_gnt_i    = 1'b0;
    dmem.dmem_rvalid_i = 1'b0;
  endtask

  // Scoreboard side: every writeback pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    #2;
    if (wbValid === 1'b1) begin
      wbCount++;
      chk("wb_expected", sbQ.size() != 0, 1'b1);
      if (sbQ.size() != 0) begin
        monExp = sbQ.pop_front();
        chk("wb_pc", pcWb, monExp.pc);
        chk("wb_regwe", wbRegWe, monExp.we);
        chk("wb_rd", rdWb, monExp.rd);
        chk("wb_data", wbData, monExp.data);
        chk("wb_err", err, monExp.err);
      end
    end else begin
      chk("idle_regwe", wbRegWe, 1'b0);
      chk("idle_err", err, 1'b0);
    end
  end

  initial begin
    rst = 1'b0;
    setIns(0, 0, 0, 0, 0, 0, 0, 0);
    dmem.dmem_gnt_i    = 1'b0;
    dmem.dmem_rvalid_i = 1'b0;
    dmem.dmem_rdata_i  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", dmem.dmem_req_o, 1'b0);
    chk("rst_wbvalid", wbValid, 1'b0);
    chk("rst_wbdata", wbData, 32'h0);
    chk("rst_pcwb", pcWb, 32'h0);
    chk("rst_rd", rdWb, 5'h0);
    @(negedge clk);
    rst = 1'b1;

    // ALU op: one-cycle latency, no stall
    @(negedge clk);
    setIns(1, 32'h40, 1, 0, 0, 5, 32'h1234, 0);
    push(32'h40, 1, 5, 32'h1234, 0);
    #1 chk("alu_stall", stall, 1'b0);
    @(negedge clk);
    // Back-to-back ALU ops, the second without a register write
    setIns(1, 32'h44, 0, 0, 0, 3, 32'h2222, 0);
    push(32'h44, 0, 3, 32'h2222, 0);
    #1;
    chk("alu_latency", wbValid, 1'b1);
    chk("alu2_stall", stall, 1'b0);
    @(negedge clk);
    // Stray gnt/rvalid in IDLE are ignored
    setIns(0, 0, 0, 0, 0, 0, 0, 0);
    dmem.dmem_gnt_i    = 1'b1;
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = 32'h77777777;
    #1 chk("stray_stall", stall, 1'b0);
    @(negedge clk);
    dmem.dmem_gnt_i    = 1'b0;
    dmem.dmem_rvalid_i = 1'b0;
    #1;
    chk("stray_no_wb", wbValid, 1'b0);
    chk("stray_no_req", dmem.dmem_req_o, 1'b0);

    // Store, gnt on the third REQ cycle; rwe=1 must be suppressed
    @(negedge clk);
    setIns(1, 32'h48, 1, 1, 0, 7, 32'h100, 32'hDEADBEEF);
    push(32'h48, 0, 7, 32'h0, 0);
    runAccess(3, 0, 0, 32'h100, 1'b1, 32'hDEADBEEF, stalls, reqs);
    chk("store_stalls", stalls, 4);
    chk("store_reqs", reqs, 3);
    chk("store_done_wb", wbValid, 1'b1);

    // Load, gnt on first REQ cycle, rvalid two cycles later
    @(negedge clk);
    setIns(1, 32'h4C, 1, 0, 1, 9, 32'h200, 0);
    push(32'h4C, 1, 9, 32'hCAFEF00D, 0);
    runAccess(1, 3, 32'hCAFEF00D, 32'h200, 1'b0, 0, stalls, reqs);
    chk("load_stalls", stalls, 4);
    chk("load_reqs", reqs, 1);

    // Load, gnt and rvalid together: REQ -> DONE directly
    @(negedge clk);
    setIns(1, 32'h50, 1, 0, 1, 10, 32'h204, 0);
    push(32'h50, 1, 10, 32'h55, 0);
    runAccess(1, 1, 32'h55, 32'h204, 1'b0, 0, stalls, reqs);
    chk("fast_load_stalls", stalls, 2);
    chk("fast_load_reqs", reqs, 1);

    // Timeout in REQ: no gnt at all
    @(negedge clk);
    setIns(1, 32'h54, 1, 0, 1, 11, 32'h300, 0);
    push(32'h54, 0, 11, 32'h0, 1);
    runAccess(0, 0, 0, 32'h300, 1'b0, 0, stalls, reqs);
    chk("tmo_req_stalls", stalls, Timeout + 1);
    chk("tmo_req_reqs", reqs, Timeout);

    // Timeout in WAIT: gnt but no rvalid
    @(negedge clk);
    setIns(1, 32'h58, 1, 0, 1, 12, 32'h304, 0);
    push(32'h58, 0, 12, 32'h0, 1);
    runAccess(1, 0, 0, 32'h304, 1'b0, 0, stalls, reqs);
    chk("tmo_wait_stalls", stalls, Timeout + 1);

    // rvalid on the expiry cycle wins over the timeout
    @(negedge clk);
    setIns(1, 32'h5C, 1, 0, 1, 13, 32'h308, 0);
    push(32'h5C, 1, 13, 32'hA5A5A5A5, 0);
    runAccess(1, Timeout, 32'hA5A5A5A5, 32'h308, 1'b0, 0, stalls, reqs);
    chk("edge_win_stalls", stalls, Timeout + 1);

    // Misaligned store address
    @(negedge clk);
    setIns(1, 32'h60, 1, 1, 0, 14, 32'h102, 32'h77);
`ifdef LSU_MISALIGN_TRAP_EN
    push(32'h60, 0, 14, 32'h0, 1);
    runAccess(1, 0, 0, 32'h100, 1'b1, 32'h77, stalls, reqs);
    chk("misalign_stalls", stalls, 1);
    chk("misalign_no_req", reqs, 0);
`else
    push(32'h60, 0, 14, 32'h0, 0);
    runAccess(1, 0, 0, 32'h100, 1'b1, 32'h77, stalls, reqs);
    chk("unaligned_stalls", stalls, 2);
    chk("unaligned_reqs", reqs, 1);
`endif

    // Reset during WAIT: access dropped, nothing retires
    @(negedge clk);
    setIns(1, 32'h64, 1, 0, 1, 15, 32'h400, 0);
    @(negedge clk);
    dmem.dmem_gnt_i = 1'b1;
    #1 chk("rstw_req", dmem.dmem_req_o, 1'b1);
    @(negedge clk);
    dmem.dmem_gnt_i = 1'b0;
    #1 chk("rstw_in_wait", stall, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_stall", stall, 1'b0);
    chk("rstw_req0", dmem.dmem_req_o, 1'b0);
    chk("rstw_wbvalid", wbValid, 1'b0);
    chk("rstw_regwe", wbRegWe, 1'b0);
    chk("rstw_err", err, 1'b0);
    chk("rstw_wbdata", wbData, 32'h0);
    chk("rstw_pcwb", pcWb, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    setIns(0, 0, 0, 0, 0, 0, 0, 0);
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = 32'h12121212;
    #1 chk("post_rst_stall", stall, 1'b0);
    @(negedge clk);
    dmem.dmem_rvalid_i = 1'b0;
    #1;
    chk("post_rst_no_wb", wbValid, 1'b0);
    chk("post_rst_no_req", dmem.dmem_req_o, 1'b0);

    repeat (3) @(negedge clk);
    #3;
    chk("sb_empty", sbQ.size(), 0);
    chk("wb_count", wbCount, pushCount);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
